fifo_arb_rx: RTL

// - Demuxes one packetised host FIFO stream into two client FIFOs; the receive-side counterpart of fifo_arb_tx.
// - Decodes each header word: SELMASK selects the destination, CNTMASK gives the payload count.
// - Forwards the header plus its payload words, unchanged and in order, to one internal `fifo` per client.
// - Sits between the host-link input FIFO (read side) and two consumers.

---
 rtl/fifo_arb_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fifo_arb_rx.sv
// Receive-side packet demux: splits one host FIFO stream into two client FIFOs
// by header destination bit, forwarding header plus payload words unchanged.

module fifo_arb_rx_fifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              rd,
  output logic [DWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              wr_ok, rd_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AWIDTH+1)'(DEPTH));
  assign rdata = rdata_q;

  // Push and pop are independent; a same-cycle pair leaves the count unchanged.
  always_comb begin
    wr_ok   = wr & ~full;
    rd_ok   = rd & ~empty;
    wptr_d  = wptr_q + AWIDTH'(wr_ok);
    rptr_d  = rptr_q + AWIDTH'(rd_ok);
    count_d = count_q + (AWIDTH+1)'(wr_ok) - (AWIDTH+1)'(rd_ok);
    rdata_d = rd_ok ? mem_q[rptr_q] : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= wdata;
  end
endmodule

// state | meaning
// S_HDR | next written word is a header; destination decoded from it
// S_PAY | forwarding payload to dest_q, cnt_q words still to write
module fifo_arb_rx #(
  parameter int              DWIDTH  = 8,
  parameter logic [DWIDTH-1:0] SELMASK = 8'h80,
  parameter logic [DWIDTH-1:0] CNTMASK = 8'h70,
  parameter int              AWIDTH  = 3
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              fifo_rdempty,
  output logic              fifo_rden,
  input  logic [DWIDTH-1:0] fifo_rddata,
  input  logic              c1_rden,
  output logic [DWIDTH-1:0] c1_rddata,
  output logic              c1_rdempty,
  input  logic              c2_rden,
  output logic [DWIDTH-1:0] c2_rddata,
  output logic              c2_rdempty
);
  localparam int CW = 3;
  localparam int PW = 3;

  function automatic int mask_lsb(logic [DWIDTH-1:0] m);
    int r;
    r = 0;
    for (int i = DWIDTH - 1; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  localparam int CNT_LSB = mask_lsb(CNTMASK);

  // Host-link mapping from header count field to payload words: one-to-one.
  function automatic logic [PW-1:0] fifo_payload(logic [CW-1:0] c);
    return PW'(c);
  endfunction

  typedef enum logic {S_HDR, S_PAY} state_t;

  state_t            state_q, state_d;
  logic              dest_q, dest_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DWIDTH-1:0] hold_q, hold_d;
  logic              en_q;

  logic [DWIDTH-1:0] word;
  logic [CW-1:0]     hdr_cnt;
  logic              word_vld, hdr_c1, dest_c1, dest_full, wr;
  logic              c1_wr, c2_wr, c1_full, c2_full;

  always_comb begin
    word       = hold_vld_q ? hold_q : fifo_rddata;
    word_vld   = hold_vld_q | rd_vld_q;
    hdr_c1     = |(word & SELMASK);
    hdr_cnt    = CW'((word & CNTMASK) >> CNT_LSB);
    dest_c1    = (state_q == S_HDR) ? hdr_c1 : dest_q;
    dest_full  = dest_c1 ? c1_full : c2_full;
    wr         = word_vld & ~dest_full;
    c1_wr      = wr & dest_c1;
    c2_wr      = wr & ~dest_c1;
    // en_q holds off popping until the first edge after reset release.
    fifo_rden  = en_q & ~fifo_rdempty & ~hold_vld_q & ~(rd_vld_q & dest_full);
    rd_vld_d   = fifo_rden;
    hold_vld_d = word_vld & ~wr;
    hold_d     = (word_vld & ~wr) ? word : hold_q;
    state_d    = state_q;
    dest_d     = dest_q;
    cnt_d      = cnt_q;
    if (wr) begin
      case (state_q)
        S_HDR: begin
          dest_d = hdr_c1;
          if (hdr_cnt != '0) begin
            cnt_d   = fifo_payload(hdr_cnt);
            state_d = S_PAY;
          end
        end
        S_PAY: begin
          if (cnt_q != '0) cnt_d = cnt_q - PW'(1);
          if (cnt_q <= PW'(1)) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_HDR;
      dest_q     <= 1'b0;
      cnt_q      <= '0;
      rd_vld_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      cnt_q      <= cnt_d;
      rd_vld_q   <= rd_vld_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      en_q       <= 1'b1;
    end
  end

  fifo_arb_rx_fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_c1 (
    .clk(CLK), .rst_n(RESETn), .wr(c1_wr), .wdata(word), .rd(c1_rden),
    .rdata(c1_rddata), .full(c1_full), .empty(c1_rdempty)
  );

  fifo_arb_rx_fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_c2 (
    .clk(CLK), .rst_n(RESETn), .wr(c2_wr), .wdata(word), .rd(c2_rden),
    .rdata(c2_rddata), .full(c2_full), .empty(c2_rdempty)
  );
endmodule
